// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if
//   Bundles the SPI pins, mode controls and word-level transmit/receive
//   signals of the TRSQ8 SPI responder.
//
//   Signals:
//     cpol, cpha  SPI mode (static while ss_n is low)
//     sclk, ss_n  SPI clock and active-low select from the master (asynchronous)
//     mosi        master-out data (asynchronous)
//     miso        slave-out data, registered, 1 when not selected
//     tx_data     word to transmit
//     tx_load     one-cycle strobe that latches tx_data into the holding register
//     tx_empty    holding register consumed or never loaded
//     rx_data     last complete received word
//     rx_valid    one-cycle pulse when rx_data updates
//     busy        responder is in a frame
//
//   Modports: slave (the core), master (the environment driving the core).
interface spi_slave_core_if #(
    parameter int D_WIDTH = 8
);
    logic               cpol;
    logic               cpha;
    logic               sclk;
    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic [D_WIDTH-1:0] tx_data;
    logic               tx_load;
    logic               tx_empty;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               busy;

    modport slave (
        input  cpol, cpha, sclk, ss_n, mosi, tx_data, tx_load,
        output miso, tx_empty, rx_data, rx_valid, busy
    );

    modport master (
        output cpol, cpha, sclk, ss_n, mosi, tx_data, tx_load,
        input  miso, tx_empty, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI responder for the TRSQ8 peripheral bus, MSB-first, all four
//   cpol/cpha modes. sclk, ss_n and mosi are synchronised into the clock
//   domain and edge-detected, so the whole block runs on one clock.
//   Transmit words come from a one-deep holding register; received words
//   are presented on rx_data with a one-cycle rx_valid strobe.
//
//   Ports:
//     clock    system clock, rising edge
//     reset_n  synchronous active-low reset
//     bus      spi_slave_core_if.slave (SPI pins, mode, tx/rx word signals)
module spi_slave_core #(
    parameter int D_WIDTH = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    spi_slave_core_if.slave bus
);

    localparam int unsigned CW = (D_WIDTH > 2) ? $clog2(D_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(D_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_q;
    state_t state_d;

    // synchronisers; sclk_s3 is the previous synced sclk for edge detection
    logic sclk_s1, sclk_s2, sclk_s3;
    logic ss_s1, ss_s2;
    logic mosi_s1, mosi_s2;

    logic [D_WIDTH-1:0] hold;
    logic               tx_empty;
    logic [D_WIDTH-1:0] tx_shift;
    logic [D_WIDTH-1:0] rx_shift;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               word_done;
    logic               miso;
    logic [CW-1:0]      cnt;

    logic lead_edge;
    logic trail_edge;
    logic enter;
    logic leave;
    logic do_sample;
    logic do_shift;
    logic last_sample;
    logic [D_WIDTH-1:0] reload_word;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            mosi_s1 <= 1'b1;
            mosi_s2 <= 1'b1;
        end else begin
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ss_s1   <= bus.ss_n;
            ss_s2   <= ss_s1;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // leading edge leaves the idle level, trailing edge returns to it
    assign lead_edge  = (sclk_s2 != sclk_s3) && (sclk_s3 == bus.cpol);
    assign trail_edge = (sclk_s2 != sclk_s3) && (sclk_s2 == bus.cpol);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        enter     = 1'b0;
        leave     = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ss_s2) begin
                    state_d = ACTIVE;
                    enter   = 1'b1;
                end
            end
            ACTIVE: begin
                // deselect wins over a coincident sclk edge
                if (ss_s2) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end else begin
                    do_sample = bus.cpha ? trail_edge : lead_edge;
                    do_shift  = bus.cpha ? lead_edge  : trail_edge;
                end
            end
        endcase
    end

    assign last_sample = do_sample && (cnt == LAST_BIT);
    assign reload_word = tx_empty ? '1 : hold;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold      <= '0;
            tx_empty  <= 1'b1;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            word_done <= 1'b0;
            miso      <= 1'b1;
            cnt       <= '0;
        end else begin
            rx_valid  <= 1'b0;
            word_done <= 1'b0;
            if (word_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end

            if (enter) begin
                cnt <= '0;
                if (bus.cpha) begin
                    tx_shift <= reload_word;
                end else begin
                    // cpha=0: MSB must be on miso before the first leading edge
                    miso     <= reload_word[D_WIDTH-1];
                    tx_shift <= {reload_word[D_WIDTH-2:0], 1'b0};
                end
            end else if (leave) begin
                cnt  <= '0;
                miso <= 1'b1;
            end else begin
                if (do_shift) begin
                    miso     <= tx_shift[D_WIDTH-1];
                    tx_shift <= {tx_shift[D_WIDTH-2:0], 1'b0};
                end
                if (do_sample) begin
                    rx_shift <= {rx_shift[D_WIDTH-2:0], mosi_s2};
                    if (last_sample) begin
                        cnt       <= '0;
                        word_done <= 1'b1;
                        tx_shift  <= reload_word;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end

            // a load coinciding with a consume leaves the new word pending
            if (bus.tx_load) begin
                hold     <= bus.tx_data;
                tx_empty <= 1'b0;
            end else if (enter || last_sample) begin
                tx_empty <= 1'b1;
            end
        end
    end

    assign bus.miso     = miso;
    assign bus.tx_empty = tx_empty;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core
//   Directed bench for spi_slave_core: acts as an SPI master bit-banging
//   frames in all four modes, with a scoreboard of words the slave must
//   receive (checked on every rx_valid) and words the master must read.
module tb_spi_slave_core;

    localparam int HALF = 8;

    logic clock;
    logic reset_n;

    spi_slave_core_if #(.D_WIDTH(8)) bus ();

    spi_slave_core #(.D_WIDTH(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] rexp[$];
    logic [7:0] mexp[$];
    logic [7:0] last_rx = 8'h00;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // scoreboard consumer for received words
    logic       mon_pending;
    logic [7:0] mon_exp;
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus.rx_valid !== 1'b0) begin
            mon_pending = (rexp.size() != 0);
            chk("rx_valid_expected", 32'(mon_pending), 32'd1);
            if (mon_pending) begin
                mon_exp = rexp.pop_front();
                chk("rx_data_word", 32'(bus.rx_data), 32'(mon_exp));
                last_rx = mon_exp;
            end
        end
    end

    task automatic pulse_load(input logic [7:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    // half period after a sample toggle; optional load lands on the
    // cycle the slave acts on that sample edge
    task automatic half_wl(input logic en, input logic [7:0] v);
        if (en) begin
            tick(2);
            pulse_load(v);
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input int load_bit,
                        input logic [7:0] load_val, output logic [7:0] mi);
        int i;
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            i = 7 - k;
            if (bus.cpha == 1'b0) begin
                bus.mosi = mo[i];
                tick(HALF);
                mi[i] = bus.miso;
                bus.sclk = ~bus.cpol;
                half_wl(k == load_bit, load_val);
                bus.sclk = bus.cpol;
            end else begin
                bus.sclk = ~bus.cpol;
                bus.mosi = mo[i];
                tick(HALF);
                mi[i] = bus.miso;
                bus.sclk = bus.cpol;
                half_wl(k == load_bit, load_val);
            end
        end
    endtask

    task automatic word(input string tag, input logic [7:0] mo, input logic [7:0] exp_mi,
                        input int load_bit, input logic [7:0] load_val);
        logic [7:0] mi;
        logic [7:0] e;
        rexp.push_back(mo);
        mexp.push_back(exp_mi);
        xfer(mo, 8, load_bit, load_val, mi);
        e = mexp.pop_front();
        chk({tag, "_miso_word"}, 32'(mi), 32'(e));
    endtask

    task automatic set_mode(input logic p, input logic h);
        bus.cpol = p;
        bus.cpha = h;
        bus.sclk = p;
        tick(8);
    endtask

    task automatic start_frame();
        bus.ss_n = 1'b0;
        tick(8);
    endtask

    task automatic end_frame(input string tag);
        tick(8);
        bus.ss_n = 1'b1;
        tick(8);
        chk({tag, "_miso_idle"}, 32'(bus.miso), 32'd1);
        chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    logic [7:0] junk;

    initial begin
        reset_n     = 1'b0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.sclk    = 1'b0;
        bus.ss_n    = 1'b1;
        bus.mosi    = 1'b1;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        tick(3);
        chk("rst_miso", 32'(bus.miso), 32'd1);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        reset_n = 1'b1;
        tick(4);

        // mode 0
        set_mode(1'b0, 1'b0);
        pulse_load(8'hA5);
        chk("m0_tx_empty_loaded", 32'(bus.tx_empty), 32'd0);
        start_frame();
        chk("m0_busy", 32'(bus.busy), 32'd1);
        chk("m0_tx_empty_consumed", 32'(bus.tx_empty), 32'd1);
        word("m0", 8'h3C, 8'hA5, -1, 8'h00);
        end_frame("m0");

        // modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            pulse_load(8'h81);
            start_frame();
            chk("mode_busy", 32'(bus.busy), 32'd1);
            word("mode", 8'h7E, 8'h81, -1, 8'h00);
            end_frame("mode");
        end

        // back-to-back, mode 1
        set_mode(1'b0, 1'b1);
        pulse_load(8'hAA);
        start_frame();
        word("b2b_w1", 8'h11, 8'hAA, 3, 8'hBB);
        word("b2b_w2", 8'h22, 8'hBB, -1, 8'h00);
        word("b2b_w3", 8'h33, 8'hFF, -1, 8'h00);
        end_frame("b2b");

        // abort after 5 bits, mode 0
        set_mode(1'b0, 1'b0);
        start_frame();
        xfer(8'hF0, 5, -1, 8'h00, junk);
        bus.ss_n = 1'b1;
        tick(8);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_miso", 32'(bus.miso), 32'd1);
        chk("abort_rx_data_kept", 32'(bus.rx_data), 32'(last_rx));
        pulse_load(8'h3C);
        start_frame();
        word("after_abort", 8'h0F, 8'h3C, -1, 8'h00);
        end_frame("after_abort");

        // load colliding with the end-of-word reload while empty
        pulse_load(8'h12);
        start_frame();
        word("coll_w1", 8'hC1, 8'h12, 7, 8'h55);
        chk("coll_tx_empty", 32'(bus.tx_empty), 32'd0);
        word("coll_w2", 8'hC2, 8'hFF, -1, 8'h00);
        word("coll_w3", 8'hC3, 8'h55, -1, 8'h00);
        end_frame("coll");

        // reset mid-frame at bit 4
        pulse_load(8'h66);
        start_frame();
        xfer(8'h99, 4, -1, 8'h00, junk);
        reset_n  = 1'b0;
        bus.ss_n = 1'b1;
        bus.sclk = bus.cpol;
        tick(1);
        chk("mrst_miso", 32'(bus.miso), 32'd1);
        chk("mrst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_tx_empty", 32'(bus.tx_empty), 32'd1);
        reset_n = 1'b1;
        tick(8);
        pulse_load(8'hC3);
        start_frame();
        word("after_rst", 8'h5A, 8'hC3, -1, 8'h00);
        end_frame("after_rst");

        tick(10);
        chk("rx_all_seen", 32'(rexp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI responder (slave) for the TRSQ8 peripheral bus: the other end of the SPI master core, sharing its `cpol`/`cpha` mode semantics and MSB-first framing. External `sclk`, `ss_n` and `mosi` are asynchronous inputs. They are synchronised and edge-detected in the `clock` domain, so the whole block is single-clock. Received words are presented as a one-cycle `rx_valid` strobe, and transmit words are supplied through a one-deep holding register.

## Interface
- `D_WIDTH`, 8, word length in bits (≥2).
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cpol`  in  1  SPI clock idle level; must be static while `ss_n` is low.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; must be static while `ss_n` is low.
- `sclk`  in  1  SPI clock from master (asynchronous).
- `ss_n`  in  1  slave select, active low (asynchronous).
- `mosi`  in  1  master-out data (asynchronous).
- `miso`  out  1  slave-out data, registered; driven 1 when not selected.
- `tx_data`  in  D_WIDTH  word to transmit.
- `tx_load`  in  1  one-cycle strobe; latches `tx_data` into the holding register.
- `tx_empty`  out  1  holding register consumed or never loaded.
- `rx_data`  out  D_WIDTH  last complete received word; holds until the next word completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  state is ACTIVE.

## Operation
- Synchronisers:
  - 2-flop synchronisers on `sclk`, `ss_n` and `mosi`.
  - A third `sclk` flop for edge detection.
  - Leading edge = synced `sclk` leaves `cpol`; trailing edge = synced `sclk` returns to `cpol`.
  - Sample edge = leading if `cpha`=0, trailing if `cpha`=1. Shift edge = the other one.
- States:
  - IDLE → ACTIVE on synced `ss_n` = 0.
  - ACTIVE → IDLE on synced `ss_n` = 1, from any bit position.
  - `sclk` edges are ignored in IDLE.
- Entry to ACTIVE:
  - Load tx shift register from the holding register, or all-ones if `tx_empty`=1.
  - Set `tx_empty` to 1.
  - Clear the bit counter.
  - If `cpha`=0: `miso` ← MSB of the loaded word and shift once in the same cycle. If `cpha`=1: `miso` is unchanged.
- Shift edge: `miso` ← tx shift MSB; tx shift ← shift left 1, 0 fill.
- Sample edge:
  - rx shift ← {rx shift[D_WIDTH-2:0], synced `mosi`}; counter +1.
  - On the D_WIDTH-th sample:
    - Counter wraps to 0.
    - Next cycle: `rx_data` ← full word, `rx_valid`=1 for exactly one cycle.
    - tx shift reloads with the full, unshifted holding word (or all-ones if empty); `tx_empty` ← 1.
    - Back-to-back words need no `ss_n` toggle.
- `tx_load` with a simultaneous reload: the shift register takes the pre-edge holding value (all-ones if empty). The holding register takes `tx_data`, and `tx_empty` ends at 0.
- `tx_load` while full overwrites silently.
- `ss_n` deassert mid-word:
  - Partial word is discarded; no `rx_valid`.
  - Counter cleared; `miso` ← 1.
  - Holding register is unchanged.
- `busy` = 1 exactly while ACTIVE.

## Timing
- Reset values:
  - `miso`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `tx_empty`=1.
  - State IDLE; counter 0; shift registers 0.
  - `sclk` sync/edge flops = 0; `ss_n` sync flops = 1; `mosi` sync flops = 1.
  - A spurious edge after reset with `cpol`=1 is ignored because the block is in IDLE.
- Reset asserted mid-word: everything returns to reset values at the next `clock` edge. Any in-progress word is lost.
- Latency from an external pin change:
  - 2 cycles to the synced value.
  - Edge acted on at cycle 3: `miso` update or sample.
  - `rx_valid` at cycle 4 after the final sample edge.
- Entry to ACTIVE: `busy` and the `cpha`=0 MSB appear 3 cycles after the `ss_n` fall.
- Usage constraints, required for correct operation:
  - `sclk` high and low times ≥ 4 `clock` periods.
  - `ss_n` low ≥ 4 cycles before the first `sclk` edge, and high ≥ 4 cycles between frames.
  - `tx_load` for word n+1 must occur before word n's last sample edge to avoid transmitting all-ones.

## Test plan
- Mode 0 (cpol=0, cpha=0), D_WIDTH=8:
  - Stimulus: `tx_load` 0xA5, then master sends 0x3C with sclk half-period 8 clocks.
  - Required: master reads 0xA5; `rx_data`=0x3C with a single `rx_valid` pulse; `tx_empty` rises at the `ss_n` fall; `miso`=1 after `ss_n` rises.
- Modes 1, 2 and 3:
  - Stimulus: the same exchange, with tx 0x81 and rx 0x7E.
  - Required: correct data in both directions in every mode.
- Back-to-back:
  - Stimulus: `ss_n` held low for 3 words (0x11, 0x22, 0x33 in), tx 0xAA / 0xBB loaded in time, third word not loaded.
  - Required: master reads 0xAA, 0xBB, 0xFF; three `rx_valid` pulses with the correct words.
- Abort:
  - Stimulus: `ss_n` rises after 5 bits of 0xF0.
  - Required: no `rx_valid`; `rx_data` keeps its previous value; `busy`→0; next full frame 0x0F is received correctly.
- Simultaneous event:
  - Stimulus: `tx_load` 0x55 on the same cycle as a reload with the holding register empty.
  - Required: the current word sent is 0xFF, the next word sent is 0x55, and `tx_empty`=0 after the collision.
- Reset mid-frame:
  - Stimulus: assert `reset_n`=0 for one cycle at bit 4.
  - Required: all outputs at reset values on the next cycle; no `rx_valid`; a fresh frame succeeds afterwards.
